colour_conversion_controller: RTL and testbench

- FSM that sequences colour_conversion_datapath to convert a planar YUV frame (320x240, two 8-bit samples per 16-bit word) into planar RGB in the same single-port 18-bit-address memory.
- Per word index: reads Y, U, V words, drives the six mux/Temp steps, writes one R, one G and one B word ({even, odd} bytes), then advances the datapath counter.
- Sits between the top-level start/done handshake, the memory port and the datapath control inputs.

---
 rtl/colour_conversion_pkg.sv | 21 ++
 rtl/colour_conversion_addr_gen.sv | 35 +++
 rtl/colour_conversion_controller.sv | 116 +++++++++++
 tb/tb_colour_conversion_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/colour_conversion_pkg.sv
// Shared definitions for the YUV->RGB conversion controller: FSM states,
// plane base addresses and Smux2 row codes.
package colour_conversion_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_Y, RD_U, RD_V, LD_V, R_E, R_O, G_E, G_O, B_E, B_O, NEXT, DONE
  } state_t;

  localparam logic [17:0] Y_BASE_DEF      = 18'd0;
  localparam logic [17:0] U_BASE_DEF      = 18'd38400;
  localparam logic [17:0] V_BASE_DEF      = 18'd76800;
  localparam logic [17:0] R_BASE_DEF      = 18'd115200;
  localparam logic [17:0] G_BASE_DEF      = 18'd153600;
  localparam logic [17:0] B_BASE_DEF      = 18'd192000;
  localparam logic [17:0] WORDS_PER_PLANE = 18'd38400;

  localparam logic [1:0] ROW_R = 2'd0;
  localparam logic [1:0] ROW_G = 2'd1;
  localparam logic [1:0] ROW_B = 2'd2;

endpackage

// File: rtl/colour_conversion_addr_gen.sv
// Maps the controller state and datapath word counter onto the memory port.
// mem_addr is held at zero whenever neither strobe is active.
module colour_conversion_addr_gen
  import colour_conversion_pkg::*;
#(
  parameter logic [17:0] Y_BASE = Y_BASE_DEF,
  parameter logic [17:0] U_BASE = U_BASE_DEF,
  parameter logic [17:0] V_BASE = V_BASE_DEF,
  parameter logic [17:0] R_BASE = R_BASE_DEF,
  parameter logic [17:0] G_BASE = G_BASE_DEF,
  parameter logic [17:0] B_BASE = B_BASE_DEF
) (
  input  state_t      state,
  input  logic [17:0] R_addr,
  output logic [17:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we
);

  always_comb begin
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    case (state)
      RD_Y: begin mem_re = 1'b1; mem_addr = Y_BASE + R_addr; end
      RD_U: begin mem_re = 1'b1; mem_addr = U_BASE + R_addr; end
      RD_V: begin mem_re = 1'b1; mem_addr = V_BASE + R_addr; end
      R_O:  begin mem_we = 1'b1; mem_addr = R_BASE + R_addr; end
      G_O:  begin mem_we = 1'b1; mem_addr = G_BASE + R_addr; end
      B_O:  begin mem_we = 1'b1; mem_addr = B_BASE + R_addr; end
      default: ;
    endcase
  end

endmodule

// File: rtl/colour_conversion_controller.sv
// Sequences the colour conversion datapath over a planar YUV frame, 11 cycles
// per word. Optional cycle counter output enabled by COLOUR_CONV_PERF_EN.
module colour_conversion_controller
  import colour_conversion_pkg::*;
#(
  parameter logic [17:0] Y_BASE = Y_BASE_DEF,
  parameter logic [17:0] U_BASE = U_BASE_DEF,
  parameter logic [17:0] V_BASE = V_BASE_DEF,
  parameter logic [17:0] R_BASE = R_BASE_DEF,
  parameter logic [17:0] G_BASE = G_BASE_DEF,
  parameter logic [17:0] B_BASE = B_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] R_addr,
  input  logic        end_of_pixel,
  output logic [17:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic        Yen_even,
  output logic        Yen_odd,
  output logic        Uen_even,
  output logic        Uen_odd,
  output logic        Ven_even,
  output logic        Ven_odd,
  output logic        Smux1,
  output logic [1:0]  Smux2,
  output logic        Temp_en,
  output logic        Cen,
  output logic        busy,
`ifdef COLOUR_CONV_PERF_EN
  output logic        done,
  output logic [19:0] cycle_count
`else
  output logic        done
`endif
);

  state_t state, next_state;
  logic   accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    Yen_even   = 1'b0;
    Yen_odd    = 1'b0;
    Uen_even   = 1'b0;
    Uen_odd    = 1'b0;
    Ven_even   = 1'b0;
    Ven_odd    = 1'b0;
    Smux1      = 1'b0;
    Smux2      = ROW_R;
    Temp_en    = 1'b0;
    Cen        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !end_of_pixel) begin
          next_state = RD_Y;
          accept     = 1'b1;
          busy       = 1'b1;
        end else if (start) begin
          next_state = DONE;
        end
      end
      RD_Y: begin busy = 1'b1; next_state = RD_U; end
      RD_U: begin busy = 1'b1; Yen_even = 1'b1; Yen_odd = 1'b1; next_state = RD_V; end
      RD_V: begin busy = 1'b1; Uen_even = 1'b1; Uen_odd = 1'b1; next_state = LD_V; end
      LD_V: begin busy = 1'b1; Ven_even = 1'b1; Ven_odd = 1'b1; next_state = R_E; end
      R_E:  begin busy = 1'b1; Smux1 = 1'b1; Smux2 = ROW_R; Temp_en = 1'b1; next_state = R_O; end
      R_O:  begin busy = 1'b1; Smux2 = ROW_R; next_state = G_E; end
      G_E:  begin busy = 1'b1; Smux1 = 1'b1; Smux2 = ROW_G; Temp_en = 1'b1; next_state = G_O; end
      G_O:  begin busy = 1'b1; Smux2 = ROW_G; next_state = B_E; end
      B_E:  begin busy = 1'b1; Smux1 = 1'b1; Smux2 = ROW_B; Temp_en = 1'b1; next_state = B_O; end
      B_O:  begin busy = 1'b1; Smux2 = ROW_B; Cen = 1'b1; next_state = NEXT; end
      NEXT: begin
        busy       = 1'b1;
        next_state = end_of_pixel ? DONE : RD_Y;
      end
      DONE: begin done = 1'b1; next_state = IDLE; end
      default: next_state = IDLE;
    endcase
  end

  colour_conversion_addr_gen #(
    .Y_BASE(Y_BASE),
    .U_BASE(U_BASE),
    .V_BASE(V_BASE),
    .R_BASE(R_BASE),
    .G_BASE(G_BASE),
    .B_BASE(B_BASE)
  ) u_addr_gen (
    .state   (state),
    .R_addr  (R_addr),
    .mem_addr(mem_addr),
    .mem_re  (mem_re),
    .mem_we  (mem_we)
  );

`ifdef COLOUR_CONV_PERF_EN
  // The acceptance cycle already counts as busy, so the clear loads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cycle_count <= '0;
    else if (accept) cycle_count <= 20'd1;
    else if (busy)   cycle_count <= cycle_count + 20'd1;
  end
`endif

endmodule

// File: tb/tb_colour_conversion_controller.sv
// Directed self-checking bench for colour_conversion_controller; the datapath
// word counter is modelled here and advanced by Cen.
module tb_colour_conversion_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] R_addr;
  logic        end_of_pixel;
  logic [17:0] mem_addr;
  logic        mem_re, mem_we;
  logic        Yen_even, Yen_odd, Uen_even, Uen_odd, Ven_even, Ven_odd;
  logic        Smux1;
  logic [1:0]  Smux2;
  logic        Temp_en, Cen, busy, done;
`ifdef COLOUR_CONV_PERF_EN
  logic [19:0] cycle_count;
`endif

  logic        load;
  logic [17:0] load_val;
  logic [14:0] obs;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load)     R_addr <= load_val;
    else if (Cen) R_addr <= R_addr + 18'd1;
  end
  assign end_of_pixel = (R_addr == 18'd38400);

  assign obs = {mem_re, mem_we, Yen_even, Yen_odd, Uen_even, Uen_odd,
                Ven_even, Ven_odd, Smux1, Smux2, Temp_en, Cen, busy, done};

  colour_conversion_controller dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .R_addr      (R_addr),
    .end_of_pixel(end_of_pixel),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .Yen_even    (Yen_even),
    .Yen_odd     (Yen_odd),
    .Uen_even    (Uen_even),
    .Uen_odd     (Uen_odd),
    .Ven_even    (Ven_even),
    .Ven_odd     (Ven_odd),
    .Smux1       (Smux1),
    .Smux2       (Smux2),
    .Temp_en     (Temp_en),
    .Cen         (Cen),
    .busy        (busy),
`ifdef COLOUR_CONV_PERF_EN
    .done        (done),
    .cycle_count (cycle_count)
`else
    .done        (done)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bit order: re we Ye Yo Ue Uo Ve Vo S1 S2[1:0] Temp Cen busy done
  function automatic logic [14:0] exp_vec(input int s);
    case (s)
      0:  return 15'b1_0_00_00_00_0_00_0_0_1_0;
      1:  return 15'b1_0_11_00_00_0_00_0_0_1_0;
      2:  return 15'b1_0_00_11_00_0_00_0_0_1_0;
      3:  return 15'b0_0_00_00_11_0_00_0_0_1_0;
      4:  return 15'b0_0_00_00_00_1_00_1_0_1_0;
      5:  return 15'b0_1_00_00_00_0_00_0_0_1_0;
      6:  return 15'b0_0_00_00_00_1_01_1_0_1_0;
      7:  return 15'b0_1_00_00_00_0_01_0_0_1_0;
      8:  return 15'b0_0_00_00_00_1_10_1_0_1_0;
      9:  return 15'b0_1_00_00_00_0_10_0_1_1_0;
      10: return 15'b0_0_00_00_00_0_00_0_0_1_0;
      default: return '0;
    endcase
  endfunction

  function automatic logic [17:0] exp_addr(input int s, input logic [17:0] r);
    case (s)
      0: return r;
      1: return 18'd38400 + r;
      2: return 18'd76800 + r;
      5: return 18'd115200 + r;
      7: return 18'd153600 + r;
      9: return 18'd192000 + r;
      default: return '0;
    endcase
  endfunction

  // Entered at the falling edge inside RD_Y; leaves at the edge after NEXT.
  task automatic run_word(input string tag, input logic [17:0] r);
    for (int s = 0; s < 11; s++) begin
      check($sformatf("%s_vec_s%0d", tag, s), 32'(obs), 32'(exp_vec(s)));
      check($sformatf("%s_addr_s%0d", tag, s), 32'(mem_addr), 32'(exp_addr(s, r)));
      if (s == 10) check($sformatf("%s_cnt_next", tag), 32'(R_addr), 32'(r + 18'd1));
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load = 1'b1; load_val = 18'd0;
    repeat (2) @(negedge clk);
    check("reset_obs", 32'(obs), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0; load = 1'b0;
    @(negedge clk);
    check("idle_obs", 32'(obs), 32'd0);

    // Single word at R_addr=0
    start = 1'b1; #1;
    check("accept_busy", 32'(busy), 32'd1);
    @(negedge clk); start = 1'b0;
    run_word("w0", 18'd0);

    // Abort mid-RD_V of the following word
    @(negedge clk); @(negedge clk);
    check("rdv_re", 32'(mem_re), 32'd1);
    check("rdv_addr", 32'(mem_addr), 32'd76801);
    rst = 1'b1; #1;
    check("abort_obs", 32'(obs), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_we", 32'(mem_we), 32'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_abort_obs", 32'(obs), 32'd0);
    end

    // Read addressing at R_addr=5
    load_val = 18'd5; load = 1'b1; @(negedge clk); load = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    run_word("w5", 18'd5);
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);

    // Last word of the frame, start held high throughout busy
    load_val = 18'd38399; load = 1'b1; @(negedge clk); load = 1'b0;
    start = 1'b1; @(negedge clk);
    run_word("wend", 18'd38399);
    start = 1'b0; #1;
    check("done_obs", 32'(obs), 32'(15'b0_0_00_00_00_0_00_0_0_0_1));
    check("done_cnt", 32'(R_addr), 32'd38400);
`ifdef COLOUR_CONV_PERF_EN
    check("perf_at_done", 32'(cycle_count), 32'd12);
`endif
    @(negedge clk);
    check("after_done_obs", 32'(obs), 32'd0);
`ifdef COLOUR_CONV_PERF_EN
    check("perf_hold", 32'(cycle_count), 32'd12);
`endif

    // Start with counter exhausted: straight to DONE, no memory access
    start = 1'b1; #1;
    check("eop_start_obs", 32'(obs), 32'd0);
    @(negedge clk); start = 1'b0; #1;
    check("eop_done_obs", 32'(obs), 32'(15'b0_0_00_00_00_0_00_0_0_0_1));
    check("eop_done_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("eop_idle_obs", 32'(obs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
